// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stores and edits the alarm time, matches it against live time and runs the ring/snooze FSM.
// Optional macro ALARM_TONE_EN: gated square-wave buzzer tone; otherwise buzzer follows ring.
module alarm_ctrl #(
  parameter int TONE_DIV   = 25000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       min_tick,
  input  logic [3:0] cur_hh,
  input  logic [3:0] cur_hl,
  input  logic [3:0] cur_mh,
  input  logic [3:0] cur_ml,
  input  logic       alarm_on,
  input  logic       set_en,
  input  logic       set_field,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic [3:0] alm_hh,
  output logic [3:0] alm_hl,
  output logic [3:0] alm_mh,
  output logic [3:0] alm_ml,
  output logic       ring,
  output logic       buzzer,
  output logic [1:0] state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;

  state_t     state_r, state_nx_s;
  logic [3:0] alm_hh_r, alm_hl_r, alm_mh_r, alm_ml_r;
  logic [7:0] ring_sec_r;
  logic [3:0] snooze_min_r;
  logic [2:0] uses_r;
  logic       ring_r, buzzer_r;
  logic       match_s, edit_s, force_idle_s;

  if (TONE_DIV < 1 || RING_SEC < 1 || RING_SEC > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 15 ||
      MAX_SNOOZE < 1 || MAX_SNOOZE > 7) begin : g_param_chk
    $error("alarm_ctrl: parameter out of range");
  end

  // Hours step 00..23 with wrap; result is {tens, units}
  function automatic logic [7:0] hour_step(input logic [3:0] t, input logic [3:0] u, input logic up);
    logic [7:0] r;
    if (up) begin
      if (t == 4'd2 && u == 4'd3)  r = 8'h00;
      else if (u == 4'd9)          r = {t + 4'd1, 4'd0};
      else                         r = {t, u + 4'd1};
    end else begin
      if (t == 4'd0 && u == 4'd0)  r = 8'h23;
      else if (u == 4'd0)          r = {t - 4'd1, 4'd9};
      else                         r = {t, u - 4'd1};
    end
    return r;
  endfunction

  // Minutes step 00..59 with wrap; result is {tens, units}
  function automatic logic [7:0] min_step(input logic [3:0] t, input logic [3:0] u, input logic up);
    logic [7:0] r;
    if (up) begin
      if (t == 4'd5 && u == 4'd9)  r = 8'h00;
      else if (u == 4'd9)          r = {t + 4'd1, 4'd0};
      else                         r = {t, u + 4'd1};
    end else begin
      if (t == 4'd0 && u == 4'd0)  r = 8'h59;
      else if (u == 4'd0)          r = {t - 4'd1, 4'd9};
      else                         r = {t, u - 4'd1};
    end
    return r;
  endfunction

  assign edit_s       = set_en & (key_up ^ key_down);
  assign force_idle_s = ~alarm_on | set_en;
  assign match_s      = min_tick & alarm_on & ~set_en &
                        ({cur_hh, cur_hl, cur_mh, cur_ml} == {alm_hh_r, alm_hl_r, alm_mh_r, alm_ml_r});

  // Alarm-time register with digit-wise BCD editing
  always_ff @(posedge clk) begin
    if (rst) begin
      {alm_hh_r, alm_hl_r, alm_mh_r, alm_ml_r} <= 16'h0000;
    end else if (edit_s) begin
      if (set_field) {alm_mh_r, alm_ml_r} <= min_step(alm_mh_r, alm_ml_r, key_up);
      else           {alm_hh_r, alm_hl_r} <= hour_step(alm_hh_r, alm_hl_r, key_up);
    end
  end

  // Next-state decision; disable/edit overrides everything, stop beats snooze
  always_comb begin
    state_nx_s = state_r;
    if (force_idle_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (match_s) state_nx_s = ST_RING;
          else         state_nx_s = ST_IDLE;
        end
        ST_RING: begin
          if (key_stop)
            state_nx_s = ST_IDLE;
          else if (key_snooze)
            state_nx_s = (uses_r < 3'(MAX_SNOOZE)) ? ST_SNOOZE : ST_IDLE;
          else if (sec_tick && ring_sec_r == 8'(RING_SEC - 1))
            state_nx_s = ST_IDLE;
          else
            state_nx_s = ST_RING;
        end
        ST_SNOOZE: begin
          if (key_stop)
            state_nx_s = ST_IDLE;
          else if (min_tick && snooze_min_r == 4'(SNOOZE_MIN - 1))
            state_nx_s = ST_RING;
          else
            state_nx_s = ST_SNOOZE;
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM state, ring output and per-state counters (cleared unless the state is held)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ring_r       <= 1'b0;
      ring_sec_r   <= 8'd0;
      snooze_min_r <= 4'd0;
      uses_r       <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      ring_r  <= (state_nx_s == ST_RING);
      if (state_r == ST_RING && state_nx_s == ST_RING) ring_sec_r <= ring_sec_r + {7'd0, sec_tick};
      else                                             ring_sec_r <= 8'd0;
      if (state_r == ST_SNOOZE && state_nx_s == ST_SNOOZE) snooze_min_r <= snooze_min_r + {3'd0, min_tick};
      else                                                 snooze_min_r <= 4'd0;
      if (state_r == ST_IDLE && state_nx_s == ST_RING)        uses_r <= 3'd0;
      else if (state_r == ST_RING && state_nx_s == ST_SNOOZE) uses_r <= uses_r + 3'd1;
    end
  end

`ifdef ALARM_TONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  logic [TW-1:0] tone_cnt_r;
  logic          tone_r, phase_r, tone_wrap_s, tone_nx_s, phase_nx_s;

  assign tone_wrap_s = (tone_cnt_r == TW'(TONE_DIV - 1));
  assign tone_nx_s   = tone_wrap_s ? ~tone_r : tone_r;
  assign phase_nx_s  = sec_tick ? ~phase_r : phase_r;

  // Tone divider and second phase run only while RING is held; phase 0 (even second) is audible
  always_ff @(posedge clk) begin
    if (rst || state_r != ST_RING || state_nx_s != ST_RING) begin
      tone_cnt_r <= '0;
      tone_r     <= 1'b0;
      phase_r    <= 1'b0;
      buzzer_r   <= 1'b0;
    end else begin
      tone_cnt_r <= tone_wrap_s ? '0 : tone_cnt_r + TW'(1);
      tone_r     <= tone_nx_s;
      phase_r    <= phase_nx_s;
      buzzer_r   <= tone_nx_s & ~phase_nx_s;
    end
  end
`else
  // Plain buzzer follows the ring state
  always_ff @(posedge clk) begin
    if (rst) buzzer_r <= 1'b0;
    else     buzzer_r <= (state_nx_s == ST_RING);
  end
`endif

  assign alm_hh = alm_hh_r;
  assign alm_hl = alm_hl_r;
  assign alm_mh = alm_mh_r;
  assign alm_ml = alm_ml_r;
  assign ring   = ring_r;
  assign buzzer = buzzer_r;
  assign state  = state_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scoreboard bench; a time-in-minutes reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0, min_tick = 1'b0;
  logic [3:0] cur_hh = 4'd0, cur_hl = 4'd0, cur_mh = 4'd0, cur_ml = 4'd0;
  logic       alarm_on = 1'b0, set_en = 1'b0, set_field = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_stop = 1'b0, key_snooze = 1'b0;
  logic [3:0] alm_hh, alm_hl, alm_mh, alm_ml;
  logic       ring, buzzer;
  logic [1:0] state;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .min_tick(min_tick),
    .cur_hh(cur_hh), .cur_hl(cur_hl), .cur_mh(cur_mh), .cur_ml(cur_ml),
    .alarm_on(alarm_on), .set_en(set_en), .set_field(set_field),
    .key_up(key_up), .key_down(key_down), .key_stop(key_stop), .key_snooze(key_snooze),
    .alm_hh(alm_hh), .alm_hl(alm_hl), .alm_mh(alm_mh), .alm_ml(alm_ml),
    .ring(ring), .buzzer(buzzer), .state(state)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        ring;
    logic        buz;
    logic [15:0] alm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: alarm held as minutes-of-day; state 0 idle, 1 ring, 2 snooze
  int m_alarm = 0, m_st = 0, m_rs = 0, m_sm = 0, m_uses = 0;
  int cur_t = 0;
  bit cur_bad = 1'b0;

  task automatic drive_cur(input int t, input bit inval);
    cur_t   = t;
    cur_bad = inval;
    cur_hh  = 4'((t / 60) / 10);
    cur_hl  = 4'((t / 60) % 10);
    cur_mh  = 4'((t % 60) / 10);
    cur_ml  = inval ? 4'hB : 4'((t % 60) % 10);
  endtask

  function automatic void model_step();
    bit match;
    int h, m, d;
    match = min_tick && alarm_on && !set_en && !cur_bad && (cur_t == m_alarm);
    if (rst) begin
      m_alarm = 0; m_st = 0; m_rs = 0; m_sm = 0; m_uses = 0;
      return;
    end
    if (set_en && (key_up != key_down)) begin
      h = m_alarm / 60;
      m = m_alarm % 60;
      d = key_up ? 1 : -1;
      if (!set_field) h = (h + d + 24) % 24;
      else            m = (m + d + 60) % 60;
      m_alarm = h * 60 + m;
    end
    if (!alarm_on || set_en) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (match) begin m_st = 1; m_rs = 0; m_uses = 0; end
    end else if (m_st == 1) begin
      if (key_stop) m_st = 0;
      else if (key_snooze) begin
        if (m_uses < 3) begin m_uses++; m_sm = 0; m_st = 2; end
        else m_st = 0;
      end else if (sec_tick) begin
        m_rs++;
        if (m_rs == 60) m_st = 0;
      end
    end else begin
      if (key_stop) m_st = 0;
      else if (min_tick) begin
        m_sm++;
        if (m_sm == 5) begin m_st = 1; m_rs = 0; end
      end
    end
  endfunction

  function automatic exp_t exp_of();
    exp_t e;
    int h, m;
    h = m_alarm / 60;
    m = m_alarm % 60;
    e.st   = 2'(m_st);
    e.ring = (m_st == 1);
    e.buz  = (m_st == 1);
    e.alm  = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    return e;
  endfunction

  // One clock: predict, clock the DUT, queue the prediction, release pulses
  task automatic cyc();
    model_step();
    @(posedge clk);
    exp_q.push_back(exp_of());
    #1;
    key_up = 1'b0; key_down = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
    sec_tick = 1'b0; min_tick = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare each queued prediction against the settled outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state", int'(state), int'(mon_e.st));
      chk("ring", int'(ring), int'(mon_e.ring));
      chk("alarm_time", int'({alm_hh, alm_hl, alm_mh, alm_ml}), int'(mon_e.alm));
`ifndef ALARM_TONE_EN
      chk("buzzer", int'(buzzer), int'(mon_e.buz));
`endif
    end
  end

  initial begin
    drive_cur(0, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;

    // Edit: 24 hour-ups wrap to 00, then down to 23, minutes down to 59, both keys = no change
    set_en = 1'b1; set_field = 1'b0;
    repeat (24) begin key_up = 1'b1; cyc(); end
    key_down = 1'b1; cyc();
    set_field = 1'b1; key_down = 1'b1; cyc();
    key_up = 1'b1; key_down = 1'b1; cyc();
    // 23:59 -> 06:30
    set_field = 1'b0;
    repeat (7) begin key_up = 1'b1; cyc(); end
    set_field = 1'b1;
    repeat (31) begin key_up = 1'b1; cyc(); end
    set_en = 1'b0; key_up = 1'b1; cyc();

    // Match and 60-second auto-stop
    alarm_on = 1'b1; drive_cur(6 * 60 + 30, 1'b0); cyc();
    min_tick = 1'b1; cyc(); cyc();
    repeat (59) begin sec_tick = 1'b1; cyc(); cyc(); end
    sec_tick = 1'b1; cyc(); cyc();
    alarm_on = 1'b0; min_tick = 1'b1; cyc();
    alarm_on = 1'b1; drive_cur(6 * 60 + 30, 1'b1); min_tick = 1'b1; cyc();
    drive_cur(6 * 60 + 30, 1'b0);

    // Snooze three times, fourth snooze stops
    min_tick = 1'b1; cyc();
    for (int r = 0; r < 4; r++) begin
      key_snooze = 1'b1; cyc();
      if (r < 3) repeat (5) begin min_tick = 1'b1; cyc(); cyc(); end
    end

    // Priorities: stop+snooze, set_en during snooze, reset during ring
    min_tick = 1'b1; cyc();
    key_stop = 1'b1; key_snooze = 1'b1; cyc();
    min_tick = 1'b1; cyc();
    key_snooze = 1'b1; cyc();
    set_en = 1'b1; cyc();
    set_en = 1'b0; min_tick = 1'b1; cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();

    // Randomised operation
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 199) == 0) alarm_on = ~alarm_on;
      if ($urandom_range(0, 149) == 0) set_en = ~set_en;
      set_field  = 1'($urandom_range(0, 1));
      key_up     = ($urandom_range(0, 3) == 0);
      key_down   = ($urandom_range(0, 3) == 0);
      key_stop   = ($urandom_range(0, 59) == 0);
      key_snooze = ($urandom_range(0, 19) == 0);
      sec_tick   = ($urandom_range(0, 3) == 0);
      min_tick   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) drive_cur(m_alarm, 1'b0);
      else drive_cur(int'($urandom_range(0, 1439)), ($urandom_range(0, 9) == 0));
      cyc();
    end
    rst = 1'b0;

    #20;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream consumer of the hour counter's BCD digits (plus the minute counter's digits); holds a user-set alarm time, compares it against live time, and drives the ring/snooze state machine and buzzer.
- Alarm digits are exported for the LCD1602 display stage.
- Keys are single-cycle debounced pulses from the existing key-scan stage.

Parameters:
- TONE_DIV, 25000, clk cycles per buzzer half-period (1 kHz at 50 MHz).
- RING_SEC, 60, sec_tick count before unattended ringing auto-stops (1..255).
- SNOOZE_MIN, 5, min_tick count spent in SNOOZE before re-ringing (1..15).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..7).

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse per second.
- min_tick  in  1  one-cycle pulse on the first cycle a new minute value is visible on cur_*.
- cur_hh, cur_hl  in  4 each  live hour tens/units BCD (0..23).
- cur_mh, cur_ml  in  4 each  live minute tens/units BCD (0..59).
- alarm_on  in  1  alarm enable switch (level).
- set_en  in  1  alarm-time edit mode (level).
- set_field  in  1  0 = edit hours, 1 = edit minutes.
- key_up, key_down  in  1 each  edit increment/decrement pulses.
- key_stop, key_snooze  in  1 each  ringing control pulses.
- alm_hh, alm_hl, alm_mh, alm_ml  out  4 each  stored alarm time, BCD.
- ring  out  1  high in RING state.
- buzzer  out  1  audio drive.
- state  out  2  0 = IDLE, 1 = RING, 2 = SNOOZE.

Behaviour:
- Reset values: alarm = 00:00, state = IDLE, ring = 0, buzzer = 0, all internal counters = 0.
- Edit (set_en = 1):
  - key_up/key_down change the selected field by ±1, digit-wise BCD.
  - Hours wrap 23→00 and 00→23; minutes wrap 59→00 and 00→59.
  - Units carry/borrow into tens.
  - key_up and key_down in the same cycle: no change.
  - Keys are ignored when set_en = 0.
  - Stored digits are never invalid BCD.
- Match event: min_tick & alarm_on & ~set_en & (cur_hh, cur_hl, cur_mh, cur_ml == alm_*). Invalid live digits simply fail to match.
- FSM, all transitions registered on clk:
  - IDLE → RING on match event; ring = 1 on the next cycle (1-cycle latency). Clear ring-second counter and snooze-use counter.
  - RING:
    - key_stop → IDLE.
    - key_snooze → SNOOZE if uses < MAX_SNOOZE (increment uses); otherwise treated as stop → IDLE.
    - key_stop wins over key_snooze in the same cycle.
    - Ring-second counter increments on sec_tick; reaching RING_SEC → IDLE.
  - SNOOZE:
    - Minute counter increments on min_tick; reaching SNOOZE_MIN → RING (ring-second counter cleared).
    - key_stop → IDLE; key_snooze ignored.
  - Any state: alarm_on = 0 or set_en = 1 → IDLE next cycle. This has priority over all other transitions.
  - A match event while in RING or SNOOZE is ignored.
- ring = (state == RING), registered.
- rst asserted mid-ring: next cycle IDLE, ring = 0, and alarm time returns to 00:00.

Optional Feature:
- Macro ALARM_TONE_EN.
- Defined: in RING, buzzer toggles every TONE_DIV clk cycles. Tone is gated by alternate seconds (audible on even seconds, silent on odd), with the phase reset on RING entry. buzzer = 0 outside RING. Tone counter is cleared whenever not in RING.
- Undefined: buzzer = ring; no tone divider is instantiated.

Test Plan:
- Edit: set_en = 1, set_field = 0, 24×key_up from 00 → alm = 00:00; then 1×key_down → 23:00. set_field = 1, key_down → 23:59.
- Match: alarm 06:30, alarm_on = 1. Drive cur = 06:30 with min_tick → ring = 1 one cycle later, state = 1. Same time with alarm_on = 0 → no ring.
- Auto-stop: in RING, apply 60 sec_tick → state = 0 on the cycle after the 60th tick. 59 ticks → still RING.
- Snooze: in RING, key_snooze → state = 2. 5 min_tick → state = 1. Repeat until the 4th key_snooze → state = 0 (MAX_SNOOZE = 3).
- Priority: key_stop and key_snooze in the same cycle → IDLE. set_en rising during SNOOZE → IDLE. rst during RING → ring = 0, alm = 00:00.
- Tone (ALARM_TONE_EN, TONE_DIV = 4): in RING on an even second, buzzer toggles every 4 clk. Odd second → buzzer = 0. Without the macro, buzzer equals ring throughout.
